// File: rtl/mem_bus_reader.sv
// Bus-initiating block reader: requests the shared memory bus, reads one word per grant and streams it out.
// First word 2 cycles after the start edge, 3 cycles per later word; the bus is released while a held word waits for out_ready.
module mem_bus_reader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic              CS,
   output logic              WE,
   output logic [ADDR_W-1:0] Address,
   inout  wire  [DATA_W-1:0] Mem_Bus,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, REQ, ADDR, HOLD, DONE} state_t;

   localparam logic [ADDR_W:0]   REM_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [ADDR_W:0]   rem_q, rem_nxt;
   logic [DATA_W-1:0] data_q, data_nxt;

   // Memory owns the data bus during reads; this block never drives it.
   assign Mem_Bus = {DATA_W{1'bz}};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         addr_q <= '0;
         rem_q  <= '0;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         addr_q <= addr_nxt;
         rem_q  <= rem_nxt;
         data_q <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      rem_nxt   = rem_q;
      data_nxt  = data_q;
      case (state)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_nxt = DONE;
               end else begin
                  addr_nxt  = base_addr;
                  rem_nxt   = len;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            if (bus_gnt) state_nxt = ADDR;
         end
         ADDR: begin
            // A grant dropped during the access discards the word and retries the same address.
            if (bus_gnt) begin
               data_nxt  = Mem_Bus;
               state_nxt = HOLD;
            end else begin
               state_nxt = REQ;
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (rem_q == REM_ONE) begin
                  state_nxt = DONE;
               end else begin
                  addr_nxt  = addr_q + ADDR_ONE;
                  rem_nxt   = rem_q - REM_ONE;
                  state_nxt = REQ;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus_req   = (state == REQ) || (state == ADDR);
   assign CS        = (state == ADDR);
   assign WE        = 1'b0;
   assign Address   = (state == ADDR) ? addr_q : '0;
   assign out_data  = data_q;
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_mem_bus_reader.sv
// Directed bench for mem_bus_reader: transaction-level model checked every cycle plus literal latency/data checks.
module tb_mem_bus_reader;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [6:0]  base_addr;
   logic [7:0]  len;
   logic        bus_req;
   logic        bus_gnt;
   logic        CS;
   logic        WE;
   logic [6:0]  Address;
   wire  [31:0] Mem_Bus;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   mem_bus_reader #(.ADDR_W(7), .DATA_W(32)) dut (
      .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .len(len),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .CS(CS), .WE(WE), .Address(Address),
      .Mem_Bus(Mem_Bus), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   initial forever #5 CLK = ~CLK;

   // Memory: reads on the negedge and drives the bus while selected for read.
   logic [31:0] ram [0:127];
   logic [31:0] mem_q;
   always @(negedge CLK) if (CS && !WE) mem_q <= ram[Address];
   assign Mem_Bus = (CS && !WE) ? mem_q : 32'bz;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int          seen_addr[$];
   logic [31:0] acc_dat[$];
   int          acc_cyc[$];
   int          vld_cyc[$];
   int          done_cyc[$];
   int          req_cnt = 0;
   bit          prev_valid = 0;

   // Model: a job is a list of addresses still to deliver plus flags for what the bus is doing.
   bit          m_busy, m_done, m_req, m_cs, m_hold;
   logic [31:0] m_word;
   int          m_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RST) begin
            chk("rst_bus_req", 32'(bus_req), 0);
            chk("rst_cs", 32'(CS), 0);
            chk("rst_we", 32'(WE), 0);
            chk("rst_address", 32'(Address), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            m_busy = 0; m_done = 0; m_req = 0; m_cs = 0; m_hold = 0;
            m_q.delete();
            prev_valid = 0;
         end else begin
            if (CS) seen_addr.push_back(int'(Address));
            if (bus_req) req_cnt++;
            if (out_valid && out_ready) begin
               acc_dat.push_back(out_data);
               acc_cyc.push_back(cyc);
            end
            if (out_valid && !prev_valid) vld_cyc.push_back(cyc);
            prev_valid = out_valid;
            if (done) done_cyc.push_back(cyc);

            chk("bus_req", 32'(bus_req), 32'(m_req || m_cs));
            chk("cs", 32'(CS), 32'(m_cs));
            chk("we", 32'(WE), 0);
            if (m_cs) chk("address", 32'(Address), 32'(m_q[0]));
            chk("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) chk("out_data", out_data, m_word);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));

            if (m_done) begin
               m_done = 0;
               m_busy = 0;
            end else if (!m_busy) begin
               if (start) begin
                  m_busy = 1;
                  if (len == 0) m_done = 1;
                  else begin
                     m_q.delete();
                     for (int i = 0; i < int'(len); i++) m_q.push_back((int'(base_addr) + i) % 128);
                     m_req = 1;
                  end
               end
            end else if (m_cs) begin
               m_cs = 0;
               if (bus_gnt) begin
                  m_word = ram[m_q[0]];
                  m_hold = 1;
               end else m_req = 1;
            end else if (m_req) begin
               if (bus_gnt) begin
                  m_req = 0;
                  m_cs  = 1;
               end
            end else if (m_hold) begin
               if (out_ready) begin
                  m_hold = 0;
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) m_done = 1;
                  else m_req = 1;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // start is high during cycle s_cyc and sampled on the edge that ends it.
   task automatic run_job(input int base, input int n, output int s_cyc);
      start     = 1'b1;
      base_addr = 7'(base);
      len       = 8'(n);
      s_cyc     = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({nm, "_done_seen"}, 32'(done), 1);
      tick();
   endtask

   initial begin
      int a0, k0, d0, v0, r0, sc, n;
      int exp_a[4];
      logic [31:0] exp_w[4];
      RST = 1'b0; start = 1'b0; base_addr = '0; len = '0; bus_gnt = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 128; i++) ram[i] = 32'h1000_0000 + i;
      ram[23] = 32'h1234_5678;
      ram[126] = 1; ram[127] = 2; ram[0] = 3; ram[1] = 4;
      ram[10] = 32'hA5A5_A5A5; ram[11] = 32'h5A5A_5A5A;
      ram[40] = 32'hCAFE_0040;
      ram[60] = 32'h6000_0060; ram[61] = 32'h6100_0061; ram[62] = 32'h6200_0062;
      fork monitor(); join_none
      repeat (2) tick();
      chk("reset_out_data", out_data, 0);
      chk("reset_busy", 32'(busy), 0);
      RST = 1'b1;
      tick();

      // 1: single word
      bus_gnt = 1; out_ready = 1;
      a0 = seen_addr.size(); k0 = acc_dat.size(); d0 = done_cyc.size(); v0 = vld_cyc.size();
      run_job(23, 1, sc);
      wait_done("t1", 20);
      chk("t1_cs_count", 32'(seen_addr.size() - a0), 1);
      chk("t1_addr", 32'(seen_addr[a0]), 23);
      chk("t1_valid_lat", 32'(vld_cyc[v0] - sc), 3);
      chk("t1_word", acc_dat[k0], 32'h1234_5678);
      chk("t1_done_lat", 32'(done_cyc[d0] - acc_cyc[k0]), 1);

      // 2: wrapping burst
      a0 = seen_addr.size(); k0 = acc_dat.size(); d0 = done_cyc.size();
      exp_a = '{126, 127, 0, 1};
      exp_w = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_job(126, 4, sc);
      wait_done("t2", 40);
      chk("t2_cs_count", 32'(seen_addr.size() - a0), 4);
      chk("t2_accepts", 32'(acc_dat.size() - k0), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_addr", 32'(seen_addr[a0 + i]), 32'(exp_a[i]));
         chk("t2_word", acc_dat[k0 + i], exp_w[i]);
      end
      chk("t2_word_gap", 32'(acc_cyc[k0 + 1] - acc_cyc[k0]), 3);
      chk("t2_done_lat", 32'(done_cyc[d0] - acc_cyc[k0 + 3]), 1);

      // 3: backpressure
      out_ready = 0;
      k0 = acc_dat.size(); r0 = req_cnt;
      run_job(10, 2, sc);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      chk("t3_valid_seen", 32'(out_valid), 1);
      r0 = req_cnt;
      repeat (5) tick();
      chk("t3_stall_valid", 32'(out_valid), 1);
      chk("t3_stall_data", out_data, 32'hA5A5_A5A5);
      chk("t3_stall_no_req", 32'(req_cnt - r0), 0);
      out_ready = 1;
      wait_done("t3", 30);
      chk("t3_accepts", 32'(acc_dat.size() - k0), 2);
      chk("t3_word0", acc_dat[k0], 32'hA5A5_A5A5);
      chk("t3_word1", acc_dat[k0 + 1], 32'h5A5A_5A5A);
      chk("t3_word_gap", 32'(acc_cyc[k0 + 1] - acc_cyc[k0]), 3);

      // 4: grant held off, then revoked during the access
      bus_gnt = 0;
      a0 = seen_addr.size(); k0 = acc_dat.size();
      run_job(40, 1, sc);
      repeat (2) tick();
      chk("t4_no_cs_ungranted", 32'(seen_addr.size() - a0), 0);
      bus_gnt = 1;
      tick();
      chk("t4_cs_on", 32'(CS), 1);
      chk("t4_cs_addr", 32'(Address), 40);
      bus_gnt = 0;
      tick();
      chk("t4_no_capture_valid", 32'(out_valid), 0);
      chk("t4_no_capture_data", out_data, 32'h5A5A_5A5A);
      chk("t4_back_to_req", 32'(bus_req), 1);
      tick();
      bus_gnt = 1;
      wait_done("t4", 20);
      chk("t4_cs_count", 32'(seen_addr.size() - a0), 2);
      chk("t4_retry_addr", 32'(seen_addr[a0 + 1]), 40);
      chk("t4_accepts", 32'(acc_dat.size() - k0), 1);
      chk("t4_word", acc_dat[k0], 32'hCAFE_0040);

      // 5a: zero length
      a0 = seen_addr.size(); d0 = done_cyc.size(); r0 = req_cnt;
      run_job(5, 0, sc);
      wait_done("t5a", 5);
      chk("t5a_done_lat", 32'(done_cyc[d0] - sc), 1);
      chk("t5a_no_cs", 32'(seen_addr.size() - a0), 0);
      chk("t5a_no_req", 32'(req_cnt - r0), 0);

      // 5b: start while busy is ignored
      a0 = seen_addr.size(); k0 = acc_dat.size(); d0 = done_cyc.size();
      run_job(60, 3, sc);
      repeat (3) tick();
      start = 1; base_addr = 7'd0; len = 8'd1;
      tick();
      start = 0;
      wait_done("t5b", 40);
      chk("t5b_accepts", 32'(acc_dat.size() - k0), 3);
      chk("t5b_word0", acc_dat[k0], 32'h6000_0060);
      chk("t5b_word2", acc_dat[k0 + 2], 32'h6200_0062);
      chk("t5b_last_addr", 32'(seen_addr[a0 + 2]), 62);
      chk("t5b_done_count", 32'(done_cyc.size() - d0), 1);

      // 6: reset during the access
      run_job(70, 2, sc);
      n = 0;
      while (CS !== 1'b1 && n < 10) begin tick(); n++; end
      chk("t6_in_access", 32'(CS), 1);
      #2 RST = 1'b0;
      #1;
      chk("t6_async_cs", 32'(CS), 0);
      chk("t6_async_req", 32'(bus_req), 0);
      chk("t6_async_valid", 32'(out_valid), 0);
      chk("t6_async_busy", 32'(busy), 0);
      repeat (2) tick();
      RST = 1'b1;
      tick();
      chk("t6_idle_after", 32'(busy), 0);
      k0 = acc_dat.size();
      run_job(23, 1, sc);
      wait_done("t6", 20);
      chk("t6_restart_word", acc_dat[k0], 32'h1234_5678);

      // 7: full-memory read wrapping from base 100
      k0 = acc_dat.size();
      run_job(100, 128, sc);
      wait_done("t7", 500);
      chk("t7_accepts", 32'(acc_dat.size() - k0), 128);
      chk("t7_first", acc_dat[k0], 32'h1000_0064);
      chk("t7_at127", acc_dat[k0 + 27], 32'd2);
      chk("t7_wrap0", acc_dat[k0 + 28], 32'd3);
      chk("t7_last", acc_dat[k0 + 127], 32'h1000_0063);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
